csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
- Execute-stage CSR/trap sequencer that sits directly upstream of the CSR register file.
- Decodes Zicsr ops, ECALL and MRET, then drives the file's single read port and single write port.
- Multi-write trap entry is serialised over several cycles on the one write port.
- Returns the old CSR value for rd and issues PC redirects to fetch.

Parameters:
XLEN, 32, data width
MEPC_ADDR, 12'h341, mepc CSR address
MCAUSE_ADDR, 12'h342, mcause CSR address
ECALL_CAUSE, 11, mcause value written on ECALL (M-mode)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
req_csr_addr  in  12  target CSR
req_src  in  XLEN  rs1 value, or zero-extended zimm for the I forms
req_src_x0  in  1  rs1 index (or zimm) is zero
req_is_ecall  in  1  request is ECALL (req_op ignored)
req_is_mret  in  1  request is MRET (req_op ignored)
req_pc  in  XLEN  PC of the instruction
rsp_valid  out  1  rd result valid, one-cycle pulse
rsp_rd_data  out  XLEN  old CSR value
redirect_valid  out  1  fetch redirect, one-cycle pulse
redirect_pc  out  XLEN  redirect target
csr_addr_r  out  12  to CSR file read address
csr_data_r  in  XLEN  combinational read data
csr_mtvec  in  XLEN  mtvec tap from the CSR file (0x305)
csr_addr_w  out  12  CSR write address
csr_data_w  out  XLEN  CSR write data
csr_we  out  1  CSR write enable; write lands on the next clk edge

Behaviour:
- Reset state: IDLE. Reset values: req_ready=1; rsp_valid, redirect_valid, csr_we = 0; rsp_rd_data, redirect_pc, csr_addr_w, csr_data_w, csr_addr_r = 0.
- Reset is asynchronous and aborts any sequence in progress with no further writes.
- Accept: req_valid && req_ready in IDLE. All request fields are latched. req_ready=0 in every state except IDLE.
- Decode priority on accept: ECALL > MRET > CSR op. req_op=000 or 100 with neither flag set: request is accepted and dropped, no response.
- EXEC (1 cycle, CSR op):
  - csr_addr_r = latched address; old = csr_data_r.
  - new = src for RW/RWI; old|src for RS/RSI; old&~src for RC/RCI.
  - csr_we=1 unless the op is RS/RC/RSI/RCI with src_x0=1. RW/RWI always write.
  - rsp_valid=1 with rsp_rd_data=old. Next state IDLE.
  - Accept-to-response latency 1 cycle; maximum throughput 1 request per 2 cycles.
- ECALL path: T_EPC -> T_CAUSE -> T_JUMP -> IDLE.
  - T_EPC: we=1, addr=MEPC_ADDR, data=pc.
  - T_CAUSE: we=1, addr=MCAUSE_ADDR, data=ECALL_CAUSE.
  - T_JUMP: redirect_valid=1, redirect_pc={csr_mtvec[XLEN-1:2],2'b00} (direct mode only). No rsp_valid.
- MRET path: M_RD (1 cycle): csr_addr_r=MEPC_ADDR, redirect_valid=1, redirect_pc=csr_data_r. Next state IDLE.
- csr_we is asserted only in EXEC, T_EPC and T_CAUSE; all write outputs hold 0 elsewhere.
- A write in EXEC to 0x305 is visible on csr_mtvec from the following cycle.

Optional Feature:
- Macro CSR_RO_CHECK_EN.
- Defined: a CSR op whose address has [11:10]==2'b11 and that would write (per the rules above) is illegal.
  - No CSR write and no rsp_valid.
  - Runs the trap sequence with mcause=2 and mepc=pc.
  - Read-only accesses (RS/RC with src_x0) proceed normally.
- Undefined: no check; every address is writable.

Test Plan:
- CSRRW 0x305, src 0x80000100, file holds 0 -> rsp_valid 1 cycle after accept, rd=0; csr_mtvec=0x80000100 the next cycle.
- CSRRS 0x340 src 0x0F, file holds 0xF0 -> rd=0xF0, csr_we=1 with data 0xFF. Repeat as CSRRC with src_x0=1 -> rd=0xFF, csr_we stays 0.
- ECALL pc 0x1000, mtvec 0x80000101 -> cycle+1 write 0x341=0x1000; cycle+2 write 0x342=11; cycle+3 redirect 0x80000100. req_ready low for 3 cycles.
- CSRRW 0x341=0x2004, then MRET -> redirect_valid with redirect_pc=0x2004 one cycle after accept.
- rst_n low during T_CAUSE -> csr_we=0 and req_ready=1 immediately; 0x342 unchanged.
- CSR_RO_CHECK_EN: CSRRW 0xC00 pc 0x40 -> no rsp; mepc=0x40, mcause=2, redirect to mtvec.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Execute-stage CSR/trap sequencer feeding a 1R/1W CSR file.
// Optional: define CSR_RO_CHECK_EN to trap writes to read-only CSRs.
module csr_trap_unit #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter int          ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_x0,
    input  logic            req_is_ecall,
    input  logic            req_is_mret,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [11:0]     csr_addr_r,
    input  logic [XLEN-1:0] csr_data_r,
    input  logic [XLEN-1:0] csr_mtvec,
    output logic [11:0]     csr_addr_w,
    output logic [XLEN-1:0] csr_data_w,
    output logic            csr_we
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        T_EPC,
        T_CAUSE,
        T_JUMP,
        M_RD
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic            x0_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;

    logic            accept;
    logic            op_ok;
    logic            op_writes;
    logic            illegal;
    logic [XLEN-1:0] cause_d;
    logic            exec_we;
    logic [XLEN-1:0] new_val;

    assign accept = req_valid && req_ready;

    // Classify the incoming request before it is latched.
    always_comb begin
        op_ok     = (req_op[1:0] != 2'b00);
        op_writes = (req_op[1:0] == 2'b01) || !req_src_x0;
`ifdef CSR_RO_CHECK_EN
        illegal   = op_ok && op_writes && (req_csr_addr[11:10] == 2'b11);
`else
        illegal   = 1'b0;
`endif
        cause_d   = req_is_ecall ? XLEN'(ECALL_CAUSE) : XLEN'(2);
    end

    // State register; reset abandons any trap sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture all request fields on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            x0_q    <= 1'b0;
            pc_q    <= '0;
            cause_q <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_csr_addr;
            src_q   <= req_src;
            x0_q    <= req_src_x0;
            pc_q    <= req_pc;
            cause_q <= cause_d;
        end
    end

    // Read-modify-write result for the latched Zicsr op.
    always_comb begin
        exec_we = (op_q[1:0] == 2'b01) || !x0_q;
        new_val = src_q;
        unique case (1'b1)
            (op_q[1:0] == 2'b10): new_val = csr_data_r | src_q;
            (op_q[1:0] == 2'b11): new_val = csr_data_r & ~src_q;
            default:              new_val = src_q;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rd_data    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_addr_r     = '0;
        csr_addr_w     = '0;
        csr_data_w     = '0;
        csr_we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_is_ecall)     state_d = T_EPC;
                    else if (req_is_mret) state_d = M_RD;
                    else if (illegal)     state_d = T_EPC;
                    else if (op_ok)       state_d = EXEC;
                    else                  state_d = IDLE;
                end
            end
            EXEC: begin
                csr_addr_r  = addr_q;
                rsp_valid   = 1'b1;
                rsp_rd_data = csr_data_r;
                csr_we      = exec_we;
                if (exec_we) begin
                    csr_addr_w = addr_q;
                    csr_data_w = new_val;
                end
                state_d = IDLE;
            end
            T_EPC: begin
                csr_we     = 1'b1;
                csr_addr_w = MEPC_ADDR;
                csr_data_w = pc_q;
                state_d    = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we     = 1'b1;
                csr_addr_w = MCAUSE_ADDR;
                csr_data_w = cause_q;
                state_d    = T_JUMP;
            end
            T_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {csr_mtvec[XLEN-1:2], 2'b00};
                state_d        = IDLE;
            end
            M_RD: begin
                csr_addr_r     = MEPC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = csr_data_r;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
